// File: rtl/pipe_ctrl_if.sv
// Handshake/control bundle between the MIPS32 datapath and the hazard/stall controller.
// Carries hazard-detection inputs (ID/EX/EX-MEM fields, data-memory ready, branch)
// and the per-register enable/flush outputs plus data-memory request/error and perf count.
interface pipe_ctrl_if;
    logic [4:0]  i_id_rs;
    logic [4:0]  i_id_rt;
    logic        i_id_uses_rt;
    logic [4:0]  i_ex_rd;
    logic        i_ex_GPRWR;
    logic        i_ex_MTR;
    logic        i_mem_DMWR;
    logic        i_mem_MTR;
    logic        i_dm_ready;
    logic        i_br_taken;
    logic        o_pc_en;
    logic        o_ifid_en;
    logic        o_ifid_flush;
    logic        o_idex_flush;
    logic        o_exmem_en;
    logic        o_memwb_flush;
    logic        o_dm_req;
    logic        o_dm_err;
    logic [31:0] o_stall_cycles;

    // Datapath side: drives hazard inputs, consumes enables/flushes.
    modport master (
        output i_id_rs, i_id_rt, i_id_uses_rt, i_ex_rd, i_ex_GPRWR, i_ex_MTR,
               i_mem_DMWR, i_mem_MTR, i_dm_ready, i_br_taken,
        input  o_pc_en, o_ifid_en, o_ifid_flush, o_idex_flush, o_exmem_en,
               o_memwb_flush, o_dm_req, o_dm_err, o_stall_cycles
    );

    // Controller side.
    modport slave (
        input  i_id_rs, i_id_rt, i_id_uses_rt, i_ex_rd, i_ex_GPRWR, i_ex_MTR,
               i_mem_DMWR, i_mem_MTR, i_dm_ready, i_br_taken,
        output o_pc_en, o_ifid_en, o_ifid_flush, o_idex_flush, o_exmem_en,
               o_memwb_flush, o_dm_req, o_dm_err, o_stall_cycles
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS32 pipeline: load-use bubbles, branch flushes,
// and pipeline freeze while an EX/MEM data-memory access waits for ready (with optional timeout).
// Ports: clk, rst (sync, active-high), bus (pipe_ctrl_if.slave). Outputs are combinational;
// only the FSM state, wait counter and optional stall counter are registered.
// Optional feature: define PIPE_PERF_EN to build the saturating stall-cycle counter.
module pipe_ctrl #(
    parameter int DM_TIMEOUT = 15,
    parameter int CNT_W      = 8
) (
    input  logic         clk,
    input  logic         rst,
    pipe_ctrl_if.slave   bus
);

    typedef enum logic {S_RUN, S_WAIT} state_t;

    localparam logic             TO_EN   = (DM_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(DM_TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;

    logic access, timeout_hit, memstall, loaduse;
    logic pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_flush, dm_req, dm_err;

    // Hazard detection.
    always_comb begin
        access      = bus.i_mem_DMWR | bus.i_mem_MTR;
        timeout_hit = (state == S_WAIT) && TO_EN && (wait_cnt == TO_LAST);
        memstall    = access & ~bus.i_dm_ready & ~timeout_hit;
        loaduse     = bus.i_ex_MTR & bus.i_ex_GPRWR & (bus.i_ex_rd != 5'd0) &
                      ((bus.i_ex_rd == bus.i_id_rs) |
                       (bus.i_id_uses_rt & (bus.i_ex_rd == bus.i_id_rt)));
    end

    // Next state: the FSM simply tracks whether this cycle stalled on memory; the
    // wait counter only runs across consecutive WAIT stall cycles.
    always_comb begin
        state_nxt    = memstall ? S_WAIT : S_RUN;
        wait_cnt_nxt = '0;
        if ((state == S_WAIT) && memstall) begin
            wait_cnt_nxt = wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Control outputs, priority rst > memstall > branch > load-use.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        memwb_flush = 1'b0;
        dm_req      = access;
        dm_err      = timeout_hit & access;
        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
            dm_req      = 1'b0;
            dm_err      = 1'b0;
        end else if (memstall) begin
            // ID/EX keeps its contents through its own hold path; only MEM/WB gets a bubble.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (bus.i_br_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
        end else if (loaduse) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_flush  = 1'b1;
        end
    end

    assign bus.o_pc_en       = pc_en;
    assign bus.o_ifid_en     = ifid_en;
    assign bus.o_ifid_flush  = ifid_flush;
    assign bus.o_idex_flush  = idex_flush;
    assign bus.o_exmem_en    = exmem_en;
    assign bus.o_memwb_flush = memwb_flush;
    assign bus.o_dm_req      = dm_req;
    assign bus.o_dm_err      = dm_err;

`ifdef PIPE_PERF_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (!pc_en && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign bus.o_stall_cycles = stall_cnt;
`else
    assign bus.o_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: each step drives inputs, pushes the expected control
// vector onto a scoreboard queue, then pops and compares it at the falling edge.
module tb_pipe_ctrl;

    localparam int TO = 4;

    // {pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_flush, dm_req, dm_err}
    localparam logic [7:0] V_RST  = 8'b0011_0100;
    localparam logic [7:0] V_NORM = 8'b1100_1000;
    localparam logic [7:0] V_REQ  = 8'b1100_1010;
    localparam logic [7:0] V_ERR  = 8'b1100_1011;
    localparam logic [7:0] V_BR   = 8'b1111_1000;
    localparam logic [7:0] V_BRQ  = 8'b1111_1010;
    localparam logic [7:0] V_LU   = 8'b0001_1000;
    localparam logic [7:0] V_MS   = 8'b0000_0110;

    typedef struct {
        string       tag;
        logic [7:0]  vec;
        logic [31:0] stall;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_stall = 32'd0;
    exp_t        sb[$];

    pipe_ctrl_if bus();

    pipe_ctrl #(.DM_TIMEOUT(TO), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic idle();
        bus.i_id_rs      = 5'd0;
        bus.i_id_rt      = 5'd0;
        bus.i_id_uses_rt = 1'b0;
        bus.i_ex_rd      = 5'd0;
        bus.i_ex_GPRWR   = 1'b0;
        bus.i_ex_MTR     = 1'b0;
        bus.i_mem_DMWR   = 1'b0;
        bus.i_mem_MTR    = 1'b0;
        bus.i_dm_ready   = 1'b0;
        bus.i_br_taken   = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [7:0] vec);
        exp_t        e;
        logic [7:0]  obs;
        e.tag = tag;
        e.vec = vec;
`ifdef PIPE_PERF_EN
        e.stall = exp_stall;
`else
        e.stall = 32'd0;
`endif
        sb.push_back(e);
        @(negedge clk);
        e   = sb.pop_front();
        obs = {bus.o_pc_en, bus.o_ifid_en, bus.o_ifid_flush, bus.o_idex_flush,
               bus.o_exmem_en, bus.o_memwb_flush, bus.o_dm_req, bus.o_dm_err};
        vectors++;
        assert (obs === e.vec) else begin
            miscompares++;
            $error("FAIL %s ctrl: got %b expected %b", e.tag, obs, e.vec);
        end
        vectors++;
        assert (bus.o_stall_cycles === e.stall) else begin
            miscompares++;
            $error("FAIL %s stall_cycles: got %0d expected %0d", e.tag, bus.o_stall_cycles, e.stall);
        end
        // Counter value seen next cycle reflects this cycle's pc_en.
        if (rst)           exp_stall = 32'd0;
        else if (!vec[7])  exp_stall = exp_stall + 32'd1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("reset", V_RST);
        rst = 1'b0;
        chk("idle", V_NORM);

        // Load-use on rs, then load moves to MEM and completes immediately.
        bus.i_ex_MTR = 1'b1; bus.i_ex_GPRWR = 1'b1; bus.i_ex_rd = 5'd5; bus.i_id_rs = 5'd5;
        chk("lu_rs", V_LU);
        idle(); bus.i_mem_MTR = 1'b1; bus.i_dm_ready = 1'b1;
        chk("lu_clear_ready_now", V_REQ);

        // rd = 0 never hazards.
        idle(); bus.i_ex_MTR = 1'b1; bus.i_ex_GPRWR = 1'b1; bus.i_ex_rd = 5'd0; bus.i_id_rs = 5'd0;
        chk("lu_rd0", V_NORM);

        // rt hazard only when rt is read.
        idle(); bus.i_ex_MTR = 1'b1; bus.i_ex_GPRWR = 1'b1; bus.i_ex_rd = 5'd7;
        bus.i_id_rs = 5'd3; bus.i_id_rt = 5'd7; bus.i_id_uses_rt = 1'b1;
        chk("lu_rt", V_LU);
        bus.i_id_uses_rt = 1'b0;
        chk("lu_rt_unused", V_NORM);
        bus.i_id_uses_rt = 1'b1; bus.i_ex_GPRWR = 1'b0;
        chk("lu_no_gprwr", V_NORM);

        // Branch beats load-use.
        bus.i_ex_GPRWR = 1'b1; bus.i_br_taken = 1'b1;
        chk("br_and_lu", V_BR);

        // Store, ready low 3 cycles then high.
        idle(); bus.i_mem_DMWR = 1'b1;
        for (int i = 0; i < 3; i++) chk("st_wait", V_MS);
        bus.i_dm_ready = 1'b1;
        chk("st_ready", V_REQ);
        idle();
        chk("st_after", V_NORM);

        // Load timeout: TO stall cycles, error pulse on the advancing cycle.
        bus.i_mem_MTR = 1'b1;
        for (int i = 0; i < TO; i++) chk("to_wait", V_MS);
        chk("to_err", V_ERR);
        bus.i_dm_ready = 1'b1;
        chk("to_next_req", V_REQ);

        // Branch during WAIT is held off until the access completes.
        idle(); bus.i_mem_DMWR = 1'b1; bus.i_br_taken = 1'b1;
        chk("br_in_wait0", V_MS);
        chk("br_in_wait1", V_MS);
        bus.i_dm_ready = 1'b1;
        chk("br_on_ready", V_BRQ);
        idle();
        chk("br_after", V_NORM);

        // Reset in WAIT aborts the access without an error and restarts the wait counter.
        bus.i_mem_DMWR = 1'b1;
        chk("rst_wait0", V_MS);
        chk("rst_wait1", V_MS);
        rst = 1'b1;
        chk("rst_mid_wait", V_RST);
        rst = 1'b0;
        for (int i = 0; i < TO; i++) chk("post_rst_wait", V_MS);
        chk("post_rst_err", V_ERR);
        idle();
        chk("final_idle", V_NORM);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
